// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared response codes, channel states and address decode for the AXI-Lite register slave
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Word index of a byte address; callers truncate to their index width.
    function automatic logic [31:0] addr_to_idx(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - word register storage, one write port and one read port; AXIL_SLAVE_RO_ID_EN makes register 0 a read-only ID
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter int          IDX_W    = 6,
    parameter logic [31:0] ID_VALUE = 32'hA11C_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [31:0]      wdata_i,
    output logic             wr_err_o,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [31:0]      rdata_o
);

`ifdef AXIL_SLAVE_RO_ID_EN
    localparam bit RO_ID_EN = 1'b1;
`else
    localparam bit RO_ID_EN = 1'b0;
`endif

    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

    logic [31:0] regs_q [NUM_REGS];
    logic        wr_in_range;

    assign wr_in_range = {1'b0, widx_i} < NUM_REGS_W;
    assign wr_err_o    = !wr_in_range || (RO_ID_EN && (widx_i == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we_i && !wr_err_o) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (widx_i == IDX_W'(i)) regs_q[i] <= wdata_i;
            end
        end
    end

    // Out-of-range indices match no register and read as zero.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx_i == IDX_W'(i)) rdata_o = regs_q[i];
        end
        if (RO_ID_EN && (ridx_i == '0)) rdata_o = ID_VALUE;
    end

endmodule

// File: rtl/axil_slave_regs.sv
// rtl/axil_slave_regs.sv - AXI-Lite slave over a register bank; AXIL_SLAVE_RO_ID_EN selects read-only ID in register 0
module axil_slave_regs
    import axil_pkg::*;
#(
    parameter int          C_AXI_DATA_WIDTH = 32,
    parameter int          C_AXI_ADDR_WIDTH = 8,
    parameter int          NUM_REGS         = 16,
    parameter logic [31:0] ID_VALUE         = 32'hA11C_0001
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESET,
    input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
    input  logic                        AXI_ARVALID,
    output logic                        AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA,
    output logic                        AXI_RVALID,
    input  logic                        AXI_RREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_AWADDR,
    input  logic                        AXI_AWVALID,
    output logic                        AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] AXI_WDATA,
    input  logic                        AXI_WVALID,
    output logic                        AXI_WREADY,
    output logic [1:0]                  AXI_BRESP,
    output logic                        AXI_BVALID,
    input  logic                        AXI_BREADY
);

    localparam int IDX_W = C_AXI_ADDR_WIDTH - 2;

    wr_state_t                   wr_q;
    logic                        aw_held_q, w_held_q;
    logic                        awready_q, wready_q, bvalid_q;
    logic [1:0]                  bresp_q;
    logic [IDX_W-1:0]            awidx_q;
    logic [C_AXI_DATA_WIDTH-1:0] wdata_q;

    rd_state_t                   rd_q;
    logic                        arready_q, rvalid_q;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_q;

    logic                        aw_hs, w_hs, ar_hs, wr_commit, wr_err;
    logic [IDX_W-1:0]            wr_idx_d, rd_idx_d;
    logic [C_AXI_DATA_WIDTH-1:0] wr_data_d, bank_rdata;

    // The write commits on the edge where the later of AW/W completes,
    // so the freshly presented half is forwarded straight to the bank.
    always_comb begin
        aw_hs     = awready_q && AXI_AWVALID;
        w_hs      = wready_q && AXI_WVALID;
        ar_hs     = arready_q && AXI_ARVALID;
        wr_idx_d  = aw_hs ? IDX_W'(addr_to_idx(32'(AXI_AWADDR))) : awidx_q;
        wr_data_d = w_hs ? AXI_WDATA : wdata_q;
        rd_idx_d  = IDX_W'(addr_to_idx(32'(AXI_ARADDR)));
        wr_commit = (wr_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    end

    axil_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk      (AXI_ACLK),
        .rst      (AXI_ARESET),
        .we_i     (wr_commit),
        .widx_i   (wr_idx_d),
        .wdata_i  (wr_data_d),
        .wr_err_o (wr_err),
        .ridx_i   (rd_idx_d),
        .rdata_o  (bank_rdata)
    );

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            wr_q      <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awidx_q   <= '0;
            wdata_q   <= '0;
        end else begin
            case (wr_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        awidx_q   <= wr_idx_d;
                    end
                    if (w_hs) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= AXI_WDATA;
                    end
                    if (wr_commit) begin
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        wr_q      <= W_RESP;
                    end else begin
                        awready_q <= !(aw_held_q || aw_hs);
                        wready_q  <= !(w_held_q || w_hs);
                    end
                end
                W_RESP: begin
                    if (AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wr_q      <= W_IDLE;
                    end
                end
                default: wr_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            rd_q      <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (rd_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata_q   <= bank_rdata;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rd_q      <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_q      <= R_IDLE;
                    end
                end
                default: rd_q <= R_IDLE;
            endcase
        end
    end

    assign AXI_AWREADY = awready_q;
    assign AXI_WREADY  = wready_q;
    assign AXI_BVALID  = bvalid_q;
    assign AXI_BRESP   = bresp_q;
    assign AXI_ARREADY = arready_q;
    assign AXI_RVALID  = rvalid_q;
    assign AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axil_slave_regs.sv
// tb/tb_axil_slave_regs.sv - scoreboard bench for axil_slave_regs; honours AXIL_SLAVE_RO_ID_EN
module tb_axil_slave_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  AXI_ARADDR, AXI_AWADDR;
    logic        AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;
    logic [31:0] AXI_RDATA, AXI_WDATA;
    logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
    logic [1:0]  AXI_BRESP;
    logic        AXI_BVALID, AXI_BREADY;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0]  sb_b[$];
    logic [31:0] sb_r[$];

    always #5 clk = ~clk;

    axil_slave_regs dut (
        .AXI_ACLK    (clk),
        .AXI_ARESET  (rst),
        .AXI_ARADDR  (AXI_ARADDR),
        .AXI_ARVALID (AXI_ARVALID),
        .AXI_ARREADY (AXI_ARREADY),
        .AXI_RDATA   (AXI_RDATA),
        .AXI_RVALID  (AXI_RVALID),
        .AXI_RREADY  (AXI_RREADY),
        .AXI_AWADDR  (AXI_AWADDR),
        .AXI_AWVALID (AXI_AWVALID),
        .AXI_AWREADY (AXI_AWREADY),
        .AXI_WDATA   (AXI_WDATA),
        .AXI_WVALID  (AXI_WVALID),
        .AXI_WREADY  (AXI_WREADY),
        .AXI_BRESP   (AXI_BRESP),
        .AXI_BVALID  (AXI_BVALID),
        .AXI_BREADY  (AXI_BREADY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a VALID/READY pair seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && AXI_BVALID && AXI_BREADY) begin
            if (sb_b.size() == 0) check("b_unexpected", 32'(AXI_BVALID), 32'(0));
            else check("bresp", 32'(AXI_BRESP), 32'(sb_b.pop_front()));
        end
        if (!rst && AXI_RVALID && AXI_RREADY) begin
            if (sb_r.size() == 0) check("r_unexpected", 32'(AXI_RVALID), 32'(0));
            else check("rdata", AXI_RDATA, sb_r.pop_front());
        end
    end

    task automatic wait_b_done();
        int k = 0;
        while (AXI_BVALID && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("b_done", 32'(AXI_BVALID), 32'(0));
    endtask

    task automatic wait_r_done();
        int k = 0;
        while (AXI_RVALID && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("r_done", 32'(AXI_RVALID), 32'(0));
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input int aw_dly, input int w_dly);
        int t = 0;
        bit aw_pend = 1'b1;
        bit w_pend  = 1'b1;
        sb_b.push_back(resp);
        AXI_AWADDR = addr;
        AXI_WDATA  = data;
        while ((aw_pend || w_pend) && t < 40) begin
            AXI_AWVALID = aw_pend && (t >= aw_dly);
            AXI_WVALID  = w_pend && (t >= w_dly);
            if (w_dly < aw_dly && t == w_dly + 1) begin
                check("w_first_wready", 32'(AXI_WREADY), 32'(0));
                check("w_first_awready", 32'(AXI_AWREADY), 32'(1));
            end
            if (AXI_AWVALID && AXI_AWREADY) aw_pend = 1'b0;
            if (AXI_WVALID && AXI_WREADY) w_pend = 1'b0;
            @(negedge clk);
            t++;
        end
        AXI_AWVALID = 1'b0;
        AXI_WVALID  = 1'b0;
        check("write_handshake_timeout", 32'(aw_pend || w_pend), 32'(0));
        check("bvalid_latency", 32'(AXI_BVALID), 32'(1));
        if (AXI_BREADY) wait_b_done();
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [31:0] exp);
        int t = 0;
        sb_r.push_back(exp);
        AXI_ARADDR  = addr;
        AXI_ARVALID = 1'b1;
        while (!AXI_ARREADY && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("ar_timeout", 32'(AXI_ARREADY), 32'(1));
        @(negedge clk);
        AXI_ARVALID = 1'b0;
        check("rvalid_latency", 32'(AXI_RVALID), 32'(1));
        if (AXI_RREADY) wait_r_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        AXI_ARADDR = '0; AXI_ARVALID = 1'b0; AXI_RREADY = 1'b1;
        AXI_AWADDR = '0; AXI_AWVALID = 1'b0; AXI_WDATA = '0; AXI_WVALID = 1'b0;
        AXI_BREADY = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_arready", 32'(AXI_ARREADY), 32'(0));
        check("rst_awready", 32'(AXI_AWREADY), 32'(0));
        check("rst_wready", 32'(AXI_WREADY), 32'(0));
        check("rst_rvalid", 32'(AXI_RVALID), 32'(0));
        check("rst_bvalid", 32'(AXI_BVALID), 32'(0));
        check("rst_rdata", AXI_RDATA, 32'h0);
        check("rst_bresp", 32'(AXI_BRESP), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // AW and W together, then read back
        do_write(8'h08, 32'hA5A5_0001, 2'b00, 0, 0);
        do_read(8'h08, 32'hA5A5_0001);

        // W three cycles ahead of AW
        do_write(8'h0C, 32'h1234_5678, 2'b00, 3, 0);
        do_read(8'h0C, 32'h1234_5678);

        // AW ahead of W
        do_write(8'h10, 32'h0F0F_1111, 2'b00, 0, 2);
        do_read(8'h10, 32'h0F0F_1111);

        // Response back-pressure
        AXI_BREADY = 1'b0;
        do_write(8'h18, 32'hCAFE_0003, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("bp_bvalid", 32'(AXI_BVALID), 32'(1));
            check("bp_bresp", 32'(AXI_BRESP), 32'(0));
            check("bp_awready", 32'(AXI_AWREADY), 32'(0));
            check("bp_wready", 32'(AXI_WREADY), 32'(0));
            @(negedge clk);
        end
        AXI_BREADY = 1'b1;
        wait_b_done();
        AXI_RREADY = 1'b0;
        do_read(8'h18, 32'hCAFE_0003);
        for (int i = 0; i < 4; i++) begin
            check("bp_rvalid", 32'(AXI_RVALID), 32'(1));
            check("bp_rdata", AXI_RDATA, 32'hCAFE_0003);
            check("bp_arready", 32'(AXI_ARREADY), 32'(0));
            @(negedge clk);
        end
        AXI_RREADY = 1'b1;
        wait_r_done();

        // Range boundaries and ignored byte-lane bits
        do_write(8'h3C, 32'h0000_BEEF, 2'b00, 0, 0);
        do_read(8'h3C, 32'h0000_BEEF);
        do_write(8'h40, 32'h5555_5555, 2'b10, 0, 0);
        do_read(8'h40, 32'h0);
        do_read(8'h08, 32'hA5A5_0001);
        do_write(8'h1F, 32'h0BAD_F00D, 2'b00, 0, 0);
        do_read(8'h1C, 32'h0BAD_F00D);

        // Same-edge read and write of one register returns the old value
        fork
            do_write(8'h14, 32'h1111_2222, 2'b00, 0, 0);
            do_read(8'h14, 32'h0);
        join
        do_read(8'h16, 32'h1111_2222);

        // Register 0
`ifdef AXIL_SLAVE_RO_ID_EN
        do_write(8'h00, 32'hFFFF_FFFF, 2'b10, 0, 0);
        do_read(8'h00, 32'hA11C_0001);
`else
        do_write(8'h00, 32'hFFFF_FFFF, 2'b00, 0, 0);
        do_read(8'h00, 32'hFFFF_FFFF);
`endif

        // Reset with a read response pending and a write address held
        AXI_RREADY  = 1'b0;
        AXI_ARADDR  = 8'h08;
        AXI_ARVALID = 1'b1;
        begin
            int t = 0;
            while (!AXI_ARREADY && t < 20) begin @(negedge clk); t++; end
        end
        @(negedge clk);
        AXI_ARVALID = 1'b0;
        check("pre_rst_rvalid", 32'(AXI_RVALID), 32'(1));
        AXI_AWADDR  = 8'h10;
        AXI_AWVALID = 1'b1;
        begin
            int t = 0;
            while (!AXI_AWREADY && t < 20) begin @(negedge clk); t++; end
        end
        @(negedge clk);
        AXI_AWVALID = 1'b0;
        check("pre_rst_aw_held", 32'(AXI_AWREADY), 32'(0));
        check("pre_rst_wready", 32'(AXI_WREADY), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_rvalid", 32'(AXI_RVALID), 32'(0));
        check("async_rst_bvalid", 32'(AXI_BVALID), 32'(0));
        check("async_rst_arready", 32'(AXI_ARREADY), 32'(0));
        check("async_rst_awready", 32'(AXI_AWREADY), 32'(0));
        check("async_rst_wready", 32'(AXI_WREADY), 32'(0));
        check("async_rst_rdata", AXI_RDATA, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        AXI_RREADY = 1'b1;
        repeat (2) @(negedge clk);
        do_read(8'h08, 32'h0);
        do_read(8'h10, 32'h0);
        do_write(8'h10, 32'h0000_0077, 2'b00, 2, 0);
        do_read(8'h10, 32'h0000_0077);

        repeat (3) @(negedge clk);
        check("sb_b_empty", 32'(sb_b.size()), 32'(0));
        check("sb_r_empty", 32'(sb_r.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_slave_regs.md
Name: axil_slave_regs

Overview:
AXI-Lite responder (slave) exposing a bank of NUM_REGS 32-bit control/status registers. Its port set is identical to the AXI-Lite checker interface, so the checker binds to it with .* in every bench. It completes read and write handshakes and returns OKAY or SLVERR responses. It is the DUT-side endpoint for the protocol assertions.

Parameters:
C_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_AXI_ADDR_WIDTH, 8, byte address width.
NUM_REGS, 16, number of word registers; must be <= 2**(C_AXI_ADDR_WIDTH-2).
ID_VALUE, 32'hA11C_0001, constant returned by register 0 when AXIL_SLAVE_RO_ID_EN is defined.

Ports:
AXI_ACLK  in  1  clock; all logic is rising-edge.
AXI_ARESET  in  1  asynchronous, active-high reset.
AXI_ARADDR  in  C_AXI_ADDR_WIDTH  read address.
AXI_ARVALID  in  1  read address valid.
AXI_ARREADY  out  1  read address ready.
AXI_RDATA  out  C_AXI_DATA_WIDTH  read data.
AXI_RVALID  out  1  read data valid.
AXI_RREADY  in  1  read data ready.
AXI_AWADDR  in  C_AXI_ADDR_WIDTH  write address.
AXI_AWVALID  in  1  write address valid.
AXI_AWREADY  out  1  write address ready.
AXI_WDATA  in  C_AXI_DATA_WIDTH  write data.
AXI_WVALID  in  1  write data valid.
AXI_WREADY  out  1  write data ready.
AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
AXI_BVALID  out  1  write response valid.
AXI_BREADY  in  1  write response ready.

Behaviour:
- One clock (AXI_ACLK); reset is asynchronous and active-high (AXI_ARESET). While reset is asserted: ARREADY, AWREADY, WREADY, RVALID, BVALID = 0; RDATA = 0; BRESP = 00; all registers = 0; holding flags cleared. Any transaction in flight when reset is asserted is dropped, with no response.
- Address decode: index = ADDR[C_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] ignored. An index >= NUM_REGS is out of range.
- Write channel FSM states:
  - W_IDLE:
    - AWREADY = !aw_held; WREADY = !w_held.
    - An AW handshake latches the address and sets aw_held. A W handshake latches the data and sets w_held.
    - AW and W may arrive in either order, any number of cycles apart, or in the same cycle.
    - On the edge where both are held (or complete together), the write commits to the register if in range, and the FSM moves to W_RESP.
  - W_RESP:
    - BVALID = 1; BRESP = 00 if in range, 10 if out of range (out-of-range write is discarded).
    - AWREADY = WREADY = 0.
    - BVALID holds until BREADY; on the handshake, flags clear and the FSM returns to W_IDLE.
  - BVALID asserts exactly one cycle after the later of the AW/W handshakes.
- Read channel FSM states:
  - R_IDLE:
    - ARREADY = 1.
    - On an AR handshake, RDATA is loaded from the register (0 if out of range) and the FSM moves to R_DATA.
  - R_DATA:
    - RVALID = 1; ARREADY = 0.
    - RDATA and RVALID are held stable until RREADY; on the handshake, return to R_IDLE.
  - RVALID asserts one cycle after the AR handshake. Sustained throughput is one read per 2 cycles.
- A read and a write to the same register on the same edge: the read returns the pre-write value.
- The read and write channels are fully independent and may be active simultaneously.
- Outputs never depend combinationally on VALID inputs; all READY/VALID outputs are registered-state decodes.

Optional Feature:
AXIL_SLAVE_RO_ID_EN.
- Defined: register 0 is read-only and always reads ID_VALUE. Writes to index 0 are discarded with BRESP = 10.
- Undefined: register 0 is an ordinary read/write register.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Enums wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
  - Function addr_to_idx.
- Sub-module axil_reg_bank: register storage with one synchronous write port, one read port, async reset, and the RO_ID handling.

Test Plan:
1. AW 0x08 and W 0xA5A5_0001 in the same cycle, BREADY = 1 -> BVALID next cycle, BRESP = 00. Then AR 0x08 -> RVALID one cycle after the handshake, RDATA = 0xA5A5_0001.
2. W 0x1234_5678 three cycles before AW 0x0C -> WREADY low after the W handshake, AWREADY still high. BVALID one cycle after the AW handshake. Read 0x0C = 0x1234_5678.
3. BREADY held low for 4 cycles -> BVALID and BRESP stable, AWREADY = WREADY = 0 throughout. Similarly, RREADY low for 4 cycles -> RDATA stable.
4. Write AW 0x40 (index 16) -> BRESP = 10, no register changes. Read 0x40 -> RDATA = 0.
5. Assert AXI_ARESET mid-cycle while RVALID = 1 and aw_held = 1 -> RVALID, BVALID, READYs = 0 immediately. After release, read 0x08 = 0.
6. With AXIL_SLAVE_RO_ID_EN defined: write 0x0 with 0xFFFF_FFFF -> BRESP = 10. Read 0x0 -> 0xA11C_0001.
